// File: rtl/jtframe_upld_pkg.sv
// Shared types and constants for the MiSTer NVRAM upload bridge.
//   upld_state_t : bridge FSM states
//   FILL_BYTE    : byte returned for out-of-range addresses or NVRAM timeouts
package jtframe_upld_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } upld_state_t;

    localparam logic [7:0] FILL_BYTE = 8'hFF;

    // Width of the NVRAM response timeout counter
    localparam int unsigned TCNT_W = 6;

endpackage

// File: rtl/jtframe_mister_upld.sv
// MiSTer HPS upload bridge: turns each HPS byte read during an NVRAM upload
// into a game NVRAM read, stalling the HPS with hps_wait until data is ready.
// Ports:
//   clk, rst_n             : clock, synchronous active-low reset
//   hps_upload, hps_index  : HPS upload session and file index
//   hps_rd, hps_addr       : one-cycle byte read request and its address
//   hps_din, hps_wait      : byte returned to the HPS and hold-off flag
//   uploading              : NVRAM upload session active (registered select)
//   nvram_addr, nvram_rd   : game NVRAM read address and level read strobe
//   nvram_din, nvram_ok    : game NVRAM data and its valid flag
//   timeout                : sticky flag, NVRAM failed to answer in time
//   byte_cnt               : bytes served in the current session (saturating)
module jtframe_mister_upld
    import jtframe_upld_pkg::*;
#(
    parameter logic [7:0]  NVRAM_INDEX = 8'd2,
    parameter int unsigned AW          = 13,
    parameter int unsigned SIZE        = 8192,
    parameter int unsigned TOUT        = 63
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hps_upload,
    input  logic [7:0]    hps_index,
    input  logic          hps_rd,
    input  logic [26:0]   hps_addr,
    output logic [7:0]    hps_din,
    output logic          hps_wait,
    output logic          uploading,
    output logic [AW-1:0] nvram_addr,
    output logic          nvram_rd,
    input  logic [7:0]    nvram_din,
    input  logic          nvram_ok,
    output logic          timeout,
    output logic [AW:0]   byte_cnt
);

    upld_state_t       state;
    logic [TCNT_W-1:0] tcnt;
    logic              sel;
    logic              in_range;

    assign sel      = hps_upload && (hps_index == NVRAM_INDEX);
    // Full 27-bit compare so any set upper bit counts as out of range
    assign in_range = {1'b0, hps_addr} < 28'(SIZE);

    // Bridge FSM; a dropped select aborts from any state without counting
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            tcnt       <= '0;
            hps_din    <= FILL_BYTE;
            hps_wait   <= 1'b0;
            uploading  <= 1'b0;
            nvram_addr <= '0;
            nvram_rd   <= 1'b0;
            timeout    <= 1'b0;
            byte_cnt   <= '0;
        end else begin
            uploading <= sel;
            if (sel && !uploading) begin
                timeout  <= 1'b0;
                byte_cnt <= '0;
            end
            if (!sel) begin
                state    <= IDLE;
                hps_wait <= 1'b0;
                nvram_rd <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (hps_rd) begin
                            hps_wait <= 1'b1;
                            if (in_range) begin
                                state      <= REQ;
                                nvram_addr <= hps_addr[AW-1:0];
                                nvram_rd   <= 1'b1;
                                tcnt       <= '0;
                            end else begin
                                state   <= FILL;
                                hps_din <= FILL_BYTE;
                            end
                        end
                    end
                    REQ: begin
                        // nvram_ok takes priority over an expiring counter
                        if (nvram_ok) begin
                            state    <= DONE;
                            hps_din  <= nvram_din;
                            nvram_rd <= 1'b0;
                        end else if (tcnt == TCNT_W'(TOUT)) begin
                            state    <= DONE;
                            hps_din  <= FILL_BYTE;
                            nvram_rd <= 1'b0;
                            timeout  <= 1'b1;
                        end else begin
                            tcnt <= tcnt + TCNT_W'(1);
                        end
                    end
                    FILL: begin
                        state <= DONE;
                    end
                    DONE: begin
                        state    <= IDLE;
                        hps_wait <= 1'b0;
                        if (byte_cnt != '1) begin
                            byte_cnt <= byte_cnt + (AW+1)'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jtframe_mister_upld.sv
// Self-checking bench for jtframe_mister_upld with a latency-programmable
// NVRAM model and a scoreboard of expected HPS bytes.
module tb_jtframe_mister_upld;

    localparam int unsigned AW = 13;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          hps_upload;
    logic [7:0]    hps_index;
    logic          hps_rd;
    logic [26:0]   hps_addr;
    logic [7:0]    hps_din;
    logic          hps_wait;
    logic          uploading;
    logic [AW-1:0] nvram_addr;
    logic          nvram_rd;
    logic [7:0]    nvram_din;
    logic          nvram_ok;
    logic          timeout;
    logic [AW:0]   byte_cnt;

    int compared = 0;
    int mism     = 0;

    logic [7:0] mem [0:8191];
    logic [7:0] sb [$];
    int         lat     = 0;
    bit         nvram_en = 1'b1;
    int         lat_cnt = 0;

    always #5 clk = ~clk;

    jtframe_mister_upld dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hps_upload (hps_upload),
        .hps_index  (hps_index),
        .hps_rd     (hps_rd),
        .hps_addr   (hps_addr),
        .hps_din    (hps_din),
        .hps_wait   (hps_wait),
        .uploading  (uploading),
        .nvram_addr (nvram_addr),
        .nvram_rd   (nvram_rd),
        .nvram_din  (nvram_din),
        .nvram_ok   (nvram_ok),
        .timeout    (timeout),
        .byte_cnt   (byte_cnt)
    );

    // NVRAM model: answers after lat cycles of nvram_rd, junk data otherwise
    always @(negedge clk) begin
        if (nvram_rd && nvram_en) begin
            if (lat_cnt >= lat) begin
                nvram_ok  <= 1'b1;
                nvram_din <= mem[nvram_addr];
            end else begin
                nvram_ok  <= 1'b0;
                nvram_din <= 8'($urandom);
                lat_cnt   <= lat_cnt + 1;
            end
        end else begin
            nvram_ok  <= 1'b0;
            nvram_din <= 8'($urandom);
            lat_cnt   <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one read, follow hps_wait, then pop and compare the returned byte
    task automatic do_read(input logic [26:0] addr, input int exp_wait, input bit extra);
        logic [7:0] e;
        logic [7:0] got;
        int         n;
        bit         in_range;
        bit         saw_rd;
        in_range = (addr < 27'd8192);
        e = (in_range && nvram_en) ? mem[addr[12:0]] : 8'hFF;
        sb.push_back(e);
        hps_addr = addr;
        hps_rd   = 1'b1;
        step();
        hps_rd = 1'b0;
        if (in_range) begin
            check("nvram_rd_start", 32'(nvram_rd), 32'd1);
            check("nvram_addr", 32'(nvram_addr), 32'(addr[12:0]));
        end
        n      = 0;
        saw_rd = 1'b0;
        while (hps_wait && n < 200) begin
            n++;
            saw_rd   = saw_rd | nvram_rd;
            hps_rd   = extra & n[0];
            hps_addr = 27'($urandom_range(0, 8191));
            step();
        end
        hps_rd = 1'b0;
        check("wait_cycles", 32'(n), 32'(exp_wait));
        if (!in_range) check("no_nvram_rd", 32'(saw_rd), 32'd0);
        got = sb.pop_front();
        check("hps_din", 32'(hps_din), 32'(got));
    endtask

    initial begin
        logic [AW:0] cnt_before;
        for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
        mem[16'h0010] = 8'h5A;

        // 1. Reset with sel active and hps_rd toggling
        rst_n      = 1'b0;
        hps_upload = 1'b1;
        hps_index  = 8'd2;
        hps_rd     = 1'b0;
        hps_addr   = 27'h10;
        for (int i = 0; i < 3; i++) begin
            hps_rd = ~hps_rd;
            step();
            check("rst_nvram_rd", 32'(nvram_rd), 32'd0);
        end
        hps_rd = 1'b0;
        check("rst_hps_din", 32'(hps_din), 32'hFF);
        check("rst_hps_wait", 32'(hps_wait), 32'd0);
        check("rst_uploading", 32'(uploading), 32'd0);
        check("rst_nvram_addr", 32'(nvram_addr), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_byte_cnt", 32'(byte_cnt), 32'd0);
        rst_n = 1'b1;
        step();
        check("uploading_on", 32'(uploading), 32'd1);

        // 2. Normal read, NVRAM answers in the first cycle of nvram_rd
        lat = 0;
        do_read(27'h10, 2, 1'b0);
        check("byte_cnt_1", 32'(byte_cnt), 32'd1);

        // 3. Out of range and last valid address
        do_read(27'd8192, 2, 1'b0);
        do_read(27'd8191, 2, 1'b0);
        do_read(27'h4000010, 2, 1'b0);
        check("byte_cnt_4", 32'(byte_cnt), 32'd4);

        // 4. Timeout, then a new session clears the flag
        nvram_en = 1'b0;
        do_read(27'h20, 65, 1'b0);
        check("timeout_set", 32'(timeout), 32'd1);
        hps_upload = 1'b0;
        step();
        hps_upload = 1'b1;
        step();
        check("timeout_clr", 32'(timeout), 32'd0);
        check("byte_cnt_clr", 32'(byte_cnt), 32'd0);

        // 5. Abort while the NVRAM request is pending
        nvram_en = 1'b1;
        do_read(27'h30, 2, 1'b0);
        nvram_en   = 1'b0;
        cnt_before = byte_cnt;
        hps_addr   = 27'h5;
        hps_rd     = 1'b1;
        step();
        hps_rd = 1'b0;
        check("abort_wait_hi", 32'(hps_wait), 32'd1);
        step();
        step();
        hps_upload = 1'b0;
        step();
        check("abort_wait", 32'(hps_wait), 32'd0);
        check("abort_nvram_rd", 32'(nvram_rd), 32'd0);
        check("abort_uploading", 32'(uploading), 32'd0);
        check("abort_byte_cnt", 32'(byte_cnt), 32'(cnt_before));
        step();
        check("abort_idle_wait", 32'(hps_wait), 32'd0);

        // 6. Wrong index ignored, then a burst with 3-cycle NVRAM latency
        nvram_en   = 1'b1;
        hps_upload = 1'b1;
        hps_index  = 8'd0;
        hps_addr   = 27'h7;
        hps_rd     = 1'b1;
        step();
        hps_rd = 1'b0;
        step();
        check("wrongidx_wait", 32'(hps_wait), 32'd0);
        check("wrongidx_rd", 32'(nvram_rd), 32'd0);
        check("wrongidx_upl", 32'(uploading), 32'd0);
        hps_index = 8'd2;
        step();
        step();
        lat = 3;
        for (int a = 0; a < 256; a++) begin
            do_read(27'(a), 5, 1'b1);
        end
        check("burst_byte_cnt", 32'(byte_cnt), 32'd256);
        check("burst_timeout", 32'(timeout), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule

// File: doc/jtframe_mister_upld.md
Name: jtframe_mister_upld

Overview:
- Serves HPS upload requests (NVRAM save to SD card); direction opposite to the ROM/NVRAM download path.
- Sits between hps_io upload signals (ioctl_upload/ioctl_rd/ioctl_addr/ioctl_din/ioctl_wait) and the game NVRAM port, on the clk_rom domain.
- Converts each HPS byte read into a game NVRAM read with a handshake.
- Holds the HPS with wait until data is valid; substitutes 0xFF on out-of-range address or game timeout.

Parameters:
- NVRAM_INDEX, 8'd2, hps_index value that selects NVRAM upload; other indexes are ignored.
- AW, 13, NVRAM byte-address width.
- SIZE, 8192, NVRAM size in bytes; addresses >= SIZE read as 0xFF.
- TOUT, 63, maximum cycles to wait for nvram_ok before substituting 0xFF (6-bit counter).

Ports:
- clk  in  1  system/ROM clock; single clock domain.
- rst_n  in  1  reset, synchronous, active low.
- hps_upload  in  1  HPS upload session active.
- hps_index  in  8  HPS file index.
- hps_rd  in  1  one-cycle byte read request.
- hps_addr  in  27  byte address of the request.
- hps_din  out  8  byte returned to HPS.
- hps_wait  out  1  HPS must hold off while high.
- uploading  out  1  NVRAM upload session active; the game may pause on it.
- nvram_addr  out  AW  NVRAM byte address.
- nvram_rd  out  1  read strobe, level, held until nvram_ok.
- nvram_din  in  8  NVRAM data.
- nvram_ok  in  1  nvram_din valid for the current nvram_addr.
- timeout  out  1  sticky; set on any timeout, cleared at the next session start.
- byte_cnt  out  AW+1  count of bytes served in the current session.

Behaviour:
- Reset values: hps_din=8'hFF, hps_wait=0, uploading=0, nvram_addr=0, nvram_rd=0, timeout=0, byte_cnt=0, state=IDLE.
- Reset asserted mid-operation returns the block to IDLE on the next edge and drops all strobes.
- sel = hps_upload && hps_index==NVRAM_INDEX.
- uploading is a registered copy of sel (1-cycle latency).
- Rising edge of sel clears timeout and byte_cnt.

FSM:
- IDLE:
  - sel && hps_rd && hps_addr<SIZE → REQ. Same edge: hps_wait=1, nvram_addr=hps_addr[AW-1:0], nvram_rd=1, tcnt=0.
  - sel && hps_rd && hps_addr>=SIZE → FILL. Same edge: hps_wait=1, hps_din=8'hFF.
  - hps_rd when !sel is ignored.
- REQ:
  - nvram_ok → DONE. Latch hps_din=nvram_din, nvram_rd=0.
  - else tcnt==TOUT → DONE. hps_din=8'hFF, nvram_rd=0, timeout=1.
  - else tcnt++.
- FILL: → DONE unconditionally.
- DONE: hps_wait=0, byte_cnt++ (saturates at 2^(AW+1)-1), → IDLE.

Timing:
- Minimum latency: hps_rd at cycle 0, nvram_ok at cycle 1 → hps_wait high on cycles 1–2, low at cycle 3 with hps_din valid.
- hps_din holds its value until the next accepted request.
- hps_rd while state!=IDLE is ignored; hps_wait already protects against it.
- nvram_ok while in IDLE is ignored.

Boundaries:
- sel falls in any state → IDLE next edge; hps_wait=0, nvram_rd=0; byte_cnt not incremented.
- Address comparison uses the full 27 bits, so upper bits set means out of range.
- hps_addr==SIZE-1 is valid; hps_addr==SIZE yields 0xFF.
- nvram_ok and tcnt==TOUT on the same cycle: nvram_ok wins and data is latched.

Decomposition:
- Package jtframe_upld_pkg:
  - state enum {IDLE, REQ, FILL, DONE}, 2 bits.
  - localparam FILL_BYTE=8'hFF.
- No sub-module. The timeout counter is inline.

Test Plan:
1. Reset: rst_n=0 for 3 cycles with hps_rd toggling → all outputs at reset values, nvram_rd never 1.
2. Normal read: sel, hps_rd at addr 0x0010, nvram_ok one cycle after nvram_rd with nvram_din=0x5A → nvram_addr=0x010, hps_wait high exactly 2 cycles, hps_din=0x5A, byte_cnt=1.
3. Out of range: hps_addr=8192 → nvram_rd stays 0, hps_wait high 2 cycles, hps_din=0xFF; hps_addr=8191 performs a real NVRAM read.
4. Timeout: nvram_ok never asserted → hps_wait released after TOUT+2 cycles, hps_din=0xFF, timeout=1. A new session (sel 0→1) clears timeout.
5. Abort: hps_upload drops while in REQ → next cycle hps_wait=0, nvram_rd=0, uploading=0, byte_cnt unchanged.
6. Wrong index and burst: hps_index=0 with hps_rd → no activity. Then 256 back-to-back reads at addr 0..255 with a 3-cycle NVRAM latency → byte_cnt=256, every hps_din matches the NVRAM model, extra hps_rd pulses while busy are ignored.
